packet_filter_cfg_master: RTL and testbench

- AXI4-Lite initiator that programs and monitors the packet filter register map from the fabric side.
- Takes a stream of 64-bit BPF instructions and writes each one as inst_low (0x08) then inst_high (0x0C).
- After the last instruction it writes Control.start (0x04).
- On request it reads Status (0x00) and returns num_packets_dropped.
- Sits between a local loader/CPU-less controller and the packet filter's AXI-Lite slave port.

---
 rtl/packet_filter_cfg_pkg.sv | 26 ++
 rtl/packet_filter_cfg_master_axil_single_xact.sv | 110 +++++++++++
 rtl/packet_filter_cfg_master.sv | 172 +++++++++++++++++
 tb/tb_packet_filter_cfg_master.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_filter_cfg_pkg.sv
// Shared register map, FSM encoding and AXI response constants for the
// packet filter configuration master.
package packet_filter_cfg_pkg;

    localparam logic [31:0] STATUS_OFFSET    = 32'h0000_0000;
    localparam logic [31:0] CONTROL_OFFSET   = 32'h0000_0004;
    localparam logic [31:0] INST_LOW_OFFSET  = 32'h0000_0008;
    localparam logic [31:0] INST_HIGH_OFFSET = 32'h0000_000C;

    localparam int unsigned STATUS_CNT_W  = 16;
    localparam logic [31:0] CONTROL_START = 32'h0000_0001;
    localparam logic [1:0]  RESP_OKAY     = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_LOW,
        ST_WR_HIGH,
        ST_WR_START,
        ST_RD_STATUS
    } state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/packet_filter_cfg_master_axil_single_xact.sv
// Runs a single AXI4-Lite write or read per go pulse; AW and W complete
// independently, the response is accepted once every address/data beat is done.
module axil_single_xact
    import packet_filter_cfg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  go_i,
    input  logic                  wr_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  done_o,
    output logic [1:0]            resp_o,
    output logic [31:0]           rdata_o,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr_o,
    output logic [2:0]            m_axi_awprot_o,
    output logic                  m_axi_awvalid_o,
    input  logic                  m_axi_awready_i,
    output logic [31:0]           m_axi_wdata_o,
    output logic [3:0]            m_axi_wstrb_o,
    output logic                  m_axi_wvalid_o,
    input  logic                  m_axi_wready_i,
    input  logic [1:0]            m_axi_bresp_i,
    input  logic                  m_axi_bvalid_i,
    output logic                  m_axi_bready_o,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr_o,
    output logic [2:0]            m_axi_arprot_o,
    output logic                  m_axi_arvalid_o,
    input  logic                  m_axi_arready_i,
    input  logic [31:0]           m_axi_rdata_i,
    input  logic [1:0]            m_axi_rresp_i,
    input  logic                  m_axi_rvalid_i,
    output logic                  m_axi_rready_o
);

    logic                  act_q, act_d;
    logic                  wr_q, wr_d;
    logic                  aw_q, aw_d;
    logic                  w_q, w_d;
    logic                  ar_q, ar_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  b_hs, r_hs;

    assign m_axi_bready_o = act_q && wr_q && !aw_q && !w_q;
    assign m_axi_rready_o = act_q && !wr_q && !ar_q;
    assign b_hs           = m_axi_bvalid_i && m_axi_bready_o;
    assign r_hs           = m_axi_rvalid_i && m_axi_rready_o;

    assign done_o  = b_hs || r_hs;
    assign resp_o  = wr_q ? m_axi_bresp_i : m_axi_rresp_i;
    assign rdata_o = m_axi_rdata_i;

    assign m_axi_awaddr_o  = addr_q;
    assign m_axi_araddr_o  = addr_q;
    assign m_axi_wdata_o   = data_q;
    assign m_axi_awprot_o  = '0;
    assign m_axi_arprot_o  = '0;
    assign m_axi_wstrb_o   = '1;
    assign m_axi_awvalid_o = aw_q;
    assign m_axi_wvalid_o  = w_q;
    assign m_axi_arvalid_o = ar_q;

    always_comb begin
        act_d  = act_q;
        wr_d   = wr_q;
        aw_d   = aw_q;
        w_d    = w_q;
        ar_d   = ar_q;
        addr_d = addr_q;
        data_d = data_q;
        if (aw_q && m_axi_awready_i) aw_d = 1'b0;
        if (w_q && m_axi_wready_i)   w_d  = 1'b0;
        if (ar_q && m_axi_arready_i) ar_d = 1'b0;
        if (done_o)                  act_d = 1'b0;
        // A new go may coincide with the previous response; it wins.
        if (go_i) begin
            act_d  = 1'b1;
            wr_d   = wr_i;
            aw_d   = wr_i;
            w_d    = wr_i;
            ar_d   = !wr_i;
            addr_d = addr_i;
            data_d = wr_i ? wdata_i : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_q  <= 1'b0;
            wr_q   <= 1'b0;
            aw_q   <= 1'b0;
            w_q    <= 1'b0;
            ar_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            act_q  <= act_d;
            wr_q   <= wr_d;
            aw_q   <= aw_d;
            w_q    <= w_d;
            ar_q   <= ar_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/packet_filter_cfg_master.sv
// AXI4-Lite initiator that loads BPF instructions into the packet filter,
// starts it, and polls its dropped-packet counter.
module packet_filter_cfg_master
    import packet_filter_cfg_pkg::*;
#(
    parameter logic [31:0]  BASEADDR   = 32'h0000_0000,
    parameter int unsigned  ADDR_WIDTH = 32
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,
    input  logic [63:0]             s_inst_tdata,
    input  logic                    s_inst_tvalid,
    output logic                    s_inst_tready,
    input  logic                    s_inst_tlast,
    input  logic                    poll_req,
    input  logic                    err_clr,
    output logic                    busy,
    output logic                    prog_done,
    output logic [STATUS_CNT_W-1:0] dropped_count,
    output logic                    dropped_valid,
    output logic                    err,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [31:0]             m_axi_wdata,
    output logic [3:0]              m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [31:0]             m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    state_e                  state_q, state_d;
    logic [31:0]             inst_hi_q;
    logic                    tlast_q;
    logic                    poll_q;
    logic                    err_q;
    logic [STATUS_CNT_W-1:0] cnt_q;
    logic                    dvalid_q;
    logic                    init_q;

    logic                    xact_go, xact_wr, xact_done;
    logic [ADDR_WIDTH-1:0]   xact_addr;
    logic [31:0]             xact_off, xact_wdata, xact_rdata;
    logic [1:0]              xact_resp;
    logic                    status_done;
    logic                    unused_status_hi;

    assign status_done      = (state_q == ST_RD_STATUS) && xact_done;
    assign unused_status_hi = ^xact_rdata[31:STATUS_CNT_W];

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (init_q) begin
                    if (poll_q)             state_d = ST_RD_STATUS;
                    else if (s_inst_tvalid) state_d = ST_WR_LOW;
                end
            end
            ST_WR_LOW:    if (xact_done) state_d = ST_WR_HIGH;
            ST_WR_HIGH:   if (xact_done) state_d = tlast_q ? ST_WR_START : ST_IDLE;
            ST_WR_START:  if (xact_done) state_d = ST_IDLE;
            ST_RD_STATUS: if (xact_done) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Transactions are launched on the transition into a bus state, so the
    // valids appear in the first cycle of that state.
    always_comb begin
        s_inst_tready = init_q && (state_q == ST_IDLE) && !poll_q;
        busy          = state_q != ST_IDLE;
        prog_done     = (state_q == ST_WR_START) && xact_done;
        xact_go       = (state_d != state_q) && (state_d != ST_IDLE);
        xact_wr       = state_d != ST_RD_STATUS;
        xact_off      = '0;
        xact_wdata    = '0;
        case (state_d)
            ST_WR_LOW: begin
                xact_off   = INST_LOW_OFFSET;
                xact_wdata = s_inst_tdata[31:0];
            end
            ST_WR_HIGH: begin
                xact_off   = INST_HIGH_OFFSET;
                xact_wdata = inst_hi_q;
            end
            ST_WR_START: begin
                xact_off   = CONTROL_OFFSET;
                xact_wdata = CONTROL_START;
            end
            ST_RD_STATUS: xact_off = STATUS_OFFSET;
            default: ;
        endcase
        xact_addr = ADDR_WIDTH'(BASEADDR + xact_off);
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            inst_hi_q <= '0;
            tlast_q   <= 1'b0;
            poll_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            dvalid_q  <= 1'b0;
            init_q    <= 1'b0;
        end else begin
            init_q <= 1'b1;
            if (s_inst_tready && s_inst_tvalid) begin
                inst_hi_q <= s_inst_tdata[63:32];
                tlast_q   <= s_inst_tlast;
            end
            poll_q   <= poll_req || (poll_q && !status_done);
            err_q    <= (err_q && !err_clr) || (xact_done && resp_is_err(xact_resp));
            dvalid_q <= status_done;
            if (status_done) cnt_q <= xact_rdata[STATUS_CNT_W-1:0];
        end
    end

    assign err           = err_q;
    assign dropped_count = cnt_q;
    assign dropped_valid = dvalid_q;

    axil_single_xact #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_xact (
        .clk_i           (axi_aclk),
        .rst_ni          (axi_aresetn),
        .go_i            (xact_go),
        .wr_i            (xact_wr),
        .addr_i          (xact_addr),
        .wdata_i         (xact_wdata),
        .done_o          (xact_done),
        .resp_o          (xact_resp),
        .rdata_o         (xact_rdata),
        .m_axi_awaddr_o  (m_axi_awaddr),
        .m_axi_awprot_o  (m_axi_awprot),
        .m_axi_awvalid_o (m_axi_awvalid),
        .m_axi_awready_i (m_axi_awready),
        .m_axi_wdata_o   (m_axi_wdata),
        .m_axi_wstrb_o   (m_axi_wstrb),
        .m_axi_wvalid_o  (m_axi_wvalid),
        .m_axi_wready_i  (m_axi_wready),
        .m_axi_bresp_i   (m_axi_bresp),
        .m_axi_bvalid_i  (m_axi_bvalid),
        .m_axi_bready_o  (m_axi_bready),
        .m_axi_araddr_o  (m_axi_araddr),
        .m_axi_arprot_o  (m_axi_arprot),
        .m_axi_arvalid_o (m_axi_arvalid),
        .m_axi_arready_i (m_axi_arready),
        .m_axi_rdata_i   (m_axi_rdata),
        .m_axi_rresp_i   (m_axi_rresp),
        .m_axi_rvalid_i  (m_axi_rvalid),
        .m_axi_rready_o  (m_axi_rready)
    );

endmodule

// File: tb/tb_packet_filter_cfg_master.sv
// Bench for packet_filter_cfg_master: AXI-Lite slave model with an in-order
// scoreboard of expected register accesses, driven from an instruction table.
module tb_packet_filter_cfg_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_inst_tdata;
    logic        s_inst_tvalid, s_inst_tready, s_inst_tlast;
    logic        poll_req, err_clr;
    logic        busy, prog_done, dropped_valid, err;
    logic [15:0] dropped_count;
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    packet_filter_cfg_master #(
        .BASEADDR   (32'h0000_0000),
        .ADDR_WIDTH (32)
    ) dut (
        .axi_aclk      (clk),
        .axi_aresetn   (rst_n),
        .s_inst_tdata  (s_inst_tdata),
        .s_inst_tvalid (s_inst_tvalid),
        .s_inst_tready (s_inst_tready),
        .s_inst_tlast  (s_inst_tlast),
        .poll_req      (poll_req),
        .err_clr       (err_clr),
        .busy          (busy),
        .prog_done     (prog_done),
        .dropped_count (dropped_count),
        .dropped_valid (dropped_valid),
        .err           (err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] data;
    } xact_t;

    typedef struct packed {
        logic [63:0] tdata;
        logic        tlast;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
    } vec_t;

    xact_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;

    // Slave knobs and state
    int          aw_dly = 0, w_dly = 0, aw_wait = 0, w_wait = 0;
    bit          aw_have, w_have, ar_have, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0] aw_cap, w_cap, ar_cap, err_addr, rd_val;
    logic [2:0]  awprot_cap, arprot_cap;
    logic [3:0]  wstrb_cap;
    bit          err_arm = 0;

    // Protocol monitors
    int          tready_busy_viol, bready_early_viol, stab_viol, prog_done_cnt, dv_cnt;
    bit          aw_first, prev_aw_pend, prev_w_pend;
    logic [31:0] prev_awaddr, prev_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic xact_t wr_x(input logic [31:0] a, input logic [31:0] d);
        xact_t x;
        x.is_rd = 1'b0; x.addr = a; x.data = d;
        return x;
    endfunction

    function automatic xact_t rd_x(input logic [31:0] a);
        xact_t x;
        x.is_rd = 1'b1; x.addr = a; x.data = '0;
        return x;
    endfunction

    always @(posedge clk) cyc++;

    // Drive slave inputs at negedge, then sample the values that will be
    // present at the following posedge.
    always begin
        xact_t e;
        @(negedge clk);
        if (!rst_n) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_bresp = 0; m_axi_rresp = 0;
            m_axi_rdata = 0;
            aw_have = 0; w_have = 0; ar_have = 0; aw_wait = 0; w_wait = 0;
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            prev_aw_pend = 0; prev_w_pend = 0;
        end else begin
            if (b_hs) m_axi_bvalid = 0;
            if (r_hs) m_axi_rvalid = 0;
            if (aw_have && w_have && !m_axi_bvalid) begin
                check("sb_wr_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_kind", e.is_rd, 0);
                    check("wr_addr", aw_cap, e.addr);
                    check("wr_data", w_cap, e.data);
                    check("wr_prot_strb", {awprot_cap, wstrb_cap}, 7'h0F);
                end
                m_axi_bresp = 2'b00;
                if (err_arm && aw_cap == err_addr) begin
                    m_axi_bresp = 2'b10;
                    err_arm     = 0;
                end
                m_axi_bvalid = 1; aw_have = 0; w_have = 0;
            end
            if (ar_have && !m_axi_rvalid) begin
                check("sb_rd_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rd_kind", e.is_rd, 1);
                    check("rd_addr", ar_cap, e.addr);
                    check("rd_prot", arprot_cap, 0);
                end
                m_axi_rdata = rd_val; m_axi_rresp = 2'b00; m_axi_rvalid = 1; ar_have = 0;
            end
            m_axi_awready = m_axi_awvalid && (aw_wait >= aw_dly);
            m_axi_wready  = m_axi_wvalid && (w_wait >= w_dly);
            m_axi_arready = m_axi_arvalid;
        end
        #2;
        if (rst_n) begin
            aw_hs = m_axi_awvalid && m_axi_awready;
            w_hs  = m_axi_wvalid && m_axi_wready;
            b_hs  = m_axi_bvalid && m_axi_bready;
            ar_hs = m_axi_arvalid && m_axi_arready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            if (aw_hs) begin
                aw_cap = m_axi_awaddr; awprot_cap = m_axi_awprot; aw_have = 1; aw_wait = 0;
            end else if (m_axi_awvalid) aw_wait++;
            if (w_hs) begin
                w_cap = m_axi_wdata; wstrb_cap = m_axi_wstrb; w_have = 1; w_wait = 0;
            end else if (m_axi_wvalid) w_wait++;
            if (ar_hs) begin
                ar_cap = m_axi_araddr; arprot_cap = m_axi_arprot; ar_have = 1;
            end
            if (busy && s_inst_tready) tready_busy_viol++;
            if (m_axi_bready && (m_axi_awvalid || m_axi_wvalid)) bready_early_viol++;
            if (prev_aw_pend && (!m_axi_awvalid || m_axi_awaddr !== prev_awaddr)) stab_viol++;
            if (prev_w_pend && (!m_axi_wvalid || m_axi_wdata !== prev_wdata)) stab_viol++;
            if (!m_axi_awvalid && m_axi_wvalid) aw_first = 1;
            if (prog_done) prog_done_cnt++;
            if (dropped_valid) dv_cnt++;
            prev_aw_pend = m_axi_awvalid && !aw_hs;
            prev_w_pend  = m_axi_wvalid && !w_hs;
            prev_awaddr  = m_axi_awaddr;
            prev_wdata   = m_axi_wdata;
        end
    end

    task automatic send_inst(input logic [63:0] d, input logic l, output int hs_cyc);
        int n = 0;
        @(negedge clk);
        s_inst_tdata = d; s_inst_tlast = l; s_inst_tvalid = 1;
        while (!s_inst_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tready_timeout", n < 200, 1);
        hs_cyc = cyc;
        @(posedge clk);
        #1 s_inst_tvalid = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while ((busy || exp_q.size() != 0) && n < 400);
        check("done_timeout", n < 400, 1);
    endtask

    task automatic push_inst(input logic [31:0] lo, input logic [31:0] hi, input logic last);
        exp_q.push_back(wr_x(32'h08, lo));
        exp_q.push_back(wr_x(32'h0C, hi));
        if (last) exp_q.push_back(wr_x(32'h04, 32'h1));
    endtask

    initial begin
        #100000;
        check("global_timeout", 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        vec_t vecs[4];
        int   hs[4];
        int   h;
        int   n;

        rst_n = 0; s_inst_tdata = '0; s_inst_tvalid = 0; s_inst_tlast = 0;
        poll_req = 0; err_clr = 0; rd_val = '0; err_addr = '0;
        repeat (3) @(negedge clk);
        #3;
        check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
        check("rst_ctrl", {s_inst_tready, busy, prog_done, dropped_valid, err}, 0);
        check("rst_count", dropped_count, 0);
        check("rst_awaddr", m_axi_awaddr, 0);
        check("rst_wdata", m_axi_wdata, 0);
        rst_n = 1;
        @(negedge clk);

        // Single-instruction program, then a three-instruction program.
        vecs[0] = '{64'h1111_2222_3333_4444, 1'b1, 32'h3333_4444, 32'h1111_2222};
        vecs[1] = '{64'hDEAD_BEEF_0000_0001, 1'b0, 32'h0000_0001, 32'hDEAD_BEEF};
        vecs[2] = '{64'hFFFF_FFFF_0000_0000, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[3] = '{64'h0123_4567_89AB_CDEF, 1'b1, 32'h89AB_CDEF, 32'h0123_4567};
        tready_busy_viol = 0;
        prog_done_cnt    = 0;
        for (int i = 0; i < 4; i++) begin
            push_inst(vecs[i].exp_lo, vecs[i].exp_hi, vecs[i].tlast);
            send_inst(vecs[i].tdata, vecs[i].tlast, hs[i]);
            if (vecs[i].tlast) begin
                wait_done();
                check("prog_done_once", prog_done_cnt, 1);
                prog_done_cnt = 0;
            end
        end
        check("inst_latency_a", hs[2] - hs[1], 5);
        check("inst_latency_b", hs[3] - hs[2], 5);
        check("tready_while_busy", tready_busy_viol, 0);
        check("err_clean", err, 0);

        // W channel back-pressured 3 cycles behind AW.
        w_dly = 3; aw_first = 0; bready_early_viol = 0; stab_viol = 0; prog_done_cnt = 0;
        push_inst(32'hC3C3_3C3C, 32'hA5A5_5A5A, 1'b1);
        send_inst(64'hA5A5_5A5A_C3C3_3C3C, 1'b1, h);
        wait_done();
        w_dly = 0;
        check("bp_aw_first", aw_first, 1);
        check("bp_bready_early", bready_early_viol, 0);
        check("bp_stable", stab_viol, 0);
        check("bp_prog_done", prog_done_cnt, 1);

        // Status poll requested during WR_LOW is serviced between instructions.
        dv_cnt = 0; prog_done_cnt = 0; rd_val = 32'h0000_002A;
        exp_q.push_back(wr_x(32'h08, 32'h0000_0010));
        exp_q.push_back(wr_x(32'h0C, 32'h0000_0020));
        exp_q.push_back(rd_x(32'h00));
        push_inst(32'h0000_0030, 32'h0000_0040, 1'b1);
        send_inst(64'h0000_0020_0000_0010, 1'b0, h);
        @(negedge clk); poll_req = 1;
        @(negedge clk); poll_req = 0;
        send_inst(64'h0000_0040_0000_0030, 1'b1, h);
        wait_done();
        check("poll_count", dropped_count, 16'd42);
        check("poll_dvalid_pulses", dv_cnt, 1);
        check("poll_prog_done", prog_done_cnt, 1);
        check("poll_err", err, 0);

        // SLVERR on inst_high: err sets, sequence still finishes, err_clr clears.
        prog_done_cnt = 0; err_addr = 32'h0C; err_arm = 1;
        push_inst(32'h7777_8888, 32'h5555_6666, 1'b1);
        send_inst(64'h5555_6666_7777_8888, 1'b1, h);
        wait_done();
        check("slverr_err_set", err, 1);
        check("slverr_prog_done", prog_done_cnt, 1);
        @(negedge clk); err_clr = 1;
        @(negedge clk); err_clr = 0;
        #3;
        check("err_cleared", err, 0);

        // Asynchronous reset while awvalid is held in WR_HIGH.
        aw_dly = 6;
        push_inst(32'hBBBB_CCCC, 32'h9999_AAAA, 1'b1);
        send_inst(64'h9999_AAAA_BBBB_CCCC, 1'b1, h);
        n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (!(m_axi_awvalid && m_axi_awaddr == 32'h0C) && n < 50);
        check("rst_wait_wr_high", n < 50, 1);
        rst_n = 0;
        #1;
        check("async_rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
        check("async_rst_busy", busy, 0);
        aw_dly = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        #3 rst_n = 1;
        @(negedge clk);
        #3;
        check("post_rst_tready", s_inst_tready, 1);
        check("post_rst_busy", busy, 0);
        prog_done_cnt = 0;
        push_inst(32'h0BAD_F00D, 32'h600D_CAFE, 1'b1);
        send_inst(64'h600D_CAFE_0BAD_F00D, 1'b1, h);
        wait_done();
        check("post_rst_prog_done", prog_done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
